// File: rtl/demux_1to2_4bit_reg.sv
// 1:2 registered demux with per-channel single-word hold, valid/ack and saturating word counters (auto-toggle routing: DEMUX_AUTO_TOGGLE_EN).
// Latency: one clk from accepted D to YA/YB; outputs are blanked combinationally while E=1.
// Backpressure: in_ready drops when the target channel holds an unconsumed word and its ack is low.
module demux_1to2_4bit_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic       E,
   input  logic       S,
   input  logic [3:0] D,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [3:0] YA,
   output logic [3:0] YB,
   output logic       A_valid,
   output logic       B_valid,
   input  logic       A_ack,
   input  logic       B_ack,
   output logic [7:0] cnt_A,
   output logic [7:0] cnt_B
);

   logic [3:0] r_ya;
   logic [3:0] r_yb;
   logic       r_a_vld;
   logic       r_b_vld;
   logic [7:0] r_cnt_a;
   logic [7:0] r_cnt_b;

   logic       w_tgt;
   logic       w_rdy_a;
   logic       w_rdy_b;
   logic       w_xfer;
   logic       w_ld_a;
   logic       w_ld_b;

`ifdef DEMUX_AUTO_TOGGLE_EN
   logic r_tog;

   // Toggle advances only on an actual transfer, so a stalled target holds the pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tog <= 1'b0;
      end else if (w_xfer) begin
         r_tog <= ~r_tog;
      end
   end

   assign w_tgt = r_tog;
`else
   assign w_tgt = S;
`endif

   // A full channel can still accept when its consumer takes the old word this cycle.
   assign w_rdy_a  = !r_a_vld || A_ack;
   assign w_rdy_b  = !r_b_vld || B_ack;
   assign in_ready = !rst && !E && (w_tgt ? w_rdy_b : w_rdy_a);
   assign w_xfer   = in_valid && in_ready;
   assign w_ld_a   = w_xfer && !w_tgt;
   assign w_ld_b   = w_xfer &&  w_tgt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ya    <= 4'd0;
         r_a_vld <= 1'b0;
         r_cnt_a <= 8'd0;
      end else if (w_ld_a) begin
         r_ya    <= D;
         r_a_vld <= 1'b1;
         if (r_cnt_a != 8'hFF) begin
            r_cnt_a <= r_cnt_a + 8'd1;
         end
      end else if (!E && A_ack && r_a_vld) begin
         r_a_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_yb    <= 4'd0;
         r_b_vld <= 1'b0;
         r_cnt_b <= 8'd0;
      end else if (w_ld_b) begin
         r_yb    <= D;
         r_b_vld <= 1'b1;
         if (r_cnt_b != 8'hFF) begin
            r_cnt_b <= r_cnt_b + 8'd1;
         end
      end else if (!E && B_ack && r_b_vld) begin
         r_b_vld <= 1'b0;
      end
   end

   // Disabled: contents are retained but hidden from the consumers.
   assign YA      = E ? 4'd0 : r_ya;
   assign YB      = E ? 4'd0 : r_yb;
   assign A_valid = !E && r_a_vld;
   assign B_valid = !E && r_b_vld;
   assign cnt_A   = r_cnt_a;
   assign cnt_B   = r_cnt_b;

endmodule

// File: tb/tb_demux_1to2_4bit_reg.sv
// Bench for demux_1to2_4bit_reg: directed scenarios plus random traffic against a channel-array reference model.
module tb_demux_1to2_4bit_reg;

   logic       clk = 1'b0;
   logic       rst, E, S, in_valid, A_ack, B_ack;
   logic [3:0] D;
   logic       in_ready, A_valid, B_valid;
   logic [3:0] YA, YB;
   logic [7:0] cnt_A, cnt_B;

   int errors = 0;
   int checks = 0;

   // Reference model: one held word, valid flag and counter per channel.
   logic [3:0] m_dat [2];
   bit         m_vld [2];
   int         m_cnt [2];
   bit         m_tog;
   bit         m_rdy;

   always #5 clk = ~clk;

   demux_1to2_4bit_reg dut (
      .clk(clk), .rst(rst), .E(E), .S(S), .D(D),
      .in_valid(in_valid), .in_ready(in_ready),
      .YA(YA), .YB(YB), .A_valid(A_valid), .B_valid(B_valid),
      .A_ack(A_ack), .B_ack(B_ack), .cnt_A(cnt_A), .cnt_B(cnt_B)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int target();
`ifdef DEMUX_AUTO_TOGGLE_EN
      return int'(m_tog);
`else
      return int'(S);
`endif
   endfunction

   function automatic bit model_ready();
      bit ack [2];
      int t;
      ack[0] = A_ack;
      ack[1] = B_ack;
      t = target();
      if (rst || E) return 1'b0;
      return !m_vld[t] || ack[t];
   endfunction

   task automatic model_edge();
      bit ack [2];
      int t;
      ack[0] = A_ack;
      ack[1] = B_ack;
      t = target();
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            m_dat[c] = 4'd0;
            m_vld[c] = 1'b0;
            m_cnt[c] = 0;
         end
         m_tog = 1'b0;
      end else if (!E) begin
         for (int c = 0; c < 2; c++) begin
            if (in_valid && m_rdy && t == c) begin
               m_dat[c] = D;
               m_vld[c] = 1'b1;
               m_cnt[c] = (m_cnt[c] >= 255) ? 255 : m_cnt[c] + 1;
            end else if (ack[c] && m_vld[c]) begin
               m_vld[c] = 1'b0;
            end
         end
         if (in_valid && m_rdy) m_tog = !m_tog;
      end
   endtask

   // Inputs are applied right after a falling edge; outputs are sampled on the next falling edge.
   task automatic step(input logic r, input logic e, input logic s, input logic [3:0] d,
                       input logic iv, input logic aa, input logic ba);
      rst = r; E = e; S = s; D = d; in_valid = iv; A_ack = aa; B_ack = ba;
      #1;
      m_rdy = model_ready();
      chk("in_ready", {7'd0, in_ready}, {7'd0, m_rdy});
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("YA",      {4'd0, YA}, E ? 8'd0 : {4'd0, m_dat[0]});
      chk("YB",      {4'd0, YB}, E ? 8'd0 : {4'd0, m_dat[1]});
      chk("A_valid", {7'd0, A_valid}, {7'd0, !E && m_vld[0]});
      chk("B_valid", {7'd0, B_valid}, {7'd0, !E && m_vld[1]});
      chk("cnt_A",   cnt_A, 8'(m_cnt[0]));
      chk("cnt_B",   cnt_B, 8'(m_cnt[1]));
   endtask

   initial begin
      m_tog = 1'b0;
      m_rdy = 1'b0;
      for (int c = 0; c < 2; c++) begin
         m_dat[c] = 4'd0; m_vld[c] = 1'b0; m_cnt[c] = 0;
      end
      rst = 1'b1; E = 1'b0; S = 1'b0; D = 4'd0; in_valid = 1'b0; A_ack = 1'b0; B_ack = 1'b0;
      @(negedge clk);

      // Reset state, with in_valid and acks asserted to show rst dominates.
      step(1, 0, 0, 4'hF, 1, 1, 1);
      step(1, 0, 0, 4'hF, 1, 1, 1);
      chk("reset_cnt_A", cnt_A, 8'd0);

`ifndef DEMUX_AUTO_TOGGLE_EN
      // Routing to A.
      step(0, 0, 0, 4'b1010, 1, 0, 0);
      chk("route_YA", {4'd0, YA}, 8'b1010);
      chk("route_cnt_A", cnt_A, 8'd1);
      // Backpressure: A full, no ack.
      step(0, 0, 0, 4'b0101, 1, 0, 0);
      chk("bp_YA", {4'd0, YA}, 8'b1010);
      // Pass-through: ack and new word in the same cycle.
      step(0, 0, 0, 4'b0101, 1, 1, 0);
      chk("pass_YA", {4'd0, YA}, 8'b0101);
      chk("pass_A_valid", {7'd0, A_valid}, 8'd1);
      // Ack on empty channel B is ignored.
      step(0, 0, 1, 4'd0, 0, 0, 1);
      // Disable with B holding 0011.
      step(0, 0, 1, 4'b0011, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 4'b1111, 1, 1, 1);
      chk("dis_YB", {4'd0, YB}, 8'd0);
      step(0, 0, 1, 4'd0, 0, 0, 0);
      chk("en_YB", {4'd0, YB}, 8'b0011);
      chk("en_B_valid", {7'd0, B_valid}, 8'd1);
`else
      // Toggle routing with S held at 1 and continuous acks.
      for (int w = 1; w <= 4; w++) step(0, 0, 1, 4'(w), 1, 1, 1);
      chk("tog_YA", {4'd0, YA}, 8'd3);
      chk("tog_YB", {4'd0, YB}, 8'd4);
      chk("tog_cnt_A", cnt_A, 8'd2);
      chk("tog_cnt_B", cnt_B, 8'd2);
      // Stalled toggle target: B is full, no acks.
      step(0, 0, 1, 4'd5, 1, 0, 0);
      step(0, 0, 1, 4'd6, 1, 0, 0);
      step(0, 0, 1, 4'd7, 1, 0, 0);
`endif

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0), 1'($urandom),
              4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      // Saturation: 300 transfers toward A (acks keep both channels drainable).
      step(1, 0, 0, 4'd0, 0, 0, 0);
      for (int i = 0; i < 300; i++) step(0, 0, 0, 4'(i), 1, 1, 1);
`ifndef DEMUX_AUTO_TOGGLE_EN
      chk("sat_cnt_A", cnt_A, 8'd255);
`else
      chk("sat_cnt_A", cnt_A, 8'd150);
`endif

      // Reset during a transfer drops the word and clears everything.
      step(1, 0, 0, 4'hF, 1, 1, 1);
      chk("rst_YA", {4'd0, YA}, 8'd0);
      chk("rst_cnt_A", cnt_A, 8'd0);
      chk("rst_A_valid", {7'd0, A_valid}, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demux_1to2_4bit_reg.md
DEMUX_1TO2_4BIT_REG -- requirements
Module: demux_1to2_4bit_reg

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port E, input, 1 bit: enable, active-low; 1 means disabled.
REQ-004 The block SHALL have the port S, input, 1 bit: channel select; 0 selects channel A, 1 selects channel B.
REQ-005 The block SHALL have the port D, input, 4 bits: data word in.
REQ-006 The block SHALL have the port in_valid, input, 1 bit: D is presented.
REQ-007 The block SHALL have the port in_ready, output, 1 bit: block accepts D this cycle.
REQ-008 The block SHALL have the ports YA and YB, outputs, 4 bits each: channel A and channel B held data.
REQ-009 The block SHALL have the ports A_valid and B_valid, outputs, 1 bit each: the channel holds an unconsumed word.
REQ-010 The block SHALL have the ports A_ack and B_ack, inputs, 1 bit each: consumer takes the held word.
REQ-011 The block SHALL have the ports cnt_A and cnt_B, outputs, 8 bits each: accepted-word counters per channel.

Function
REQ-012 The target channel T SHALL be S, or the toggle bit under DEMUX_AUTO_TOGGLE_EN.
REQ-013 A transfer SHALL occur when in_valid=1 and in_ready=1 are both present at a rising clk edge.
REQ-014 in_ready SHALL be combinational: E==0 and (target channel empty, or target channel's ack=1 in the same cycle).
REQ-015 On a transfer, D SHALL be registered into the target channel, and its valid flag SHALL be set after that edge (latency 1 cycle).
REQ-016 The non-target channel's data SHALL be unchanged by a transfer.
REQ-017 A channel's valid flag SHALL clear at an edge where its ack=1 and valid=1 and no transfer targets it in that cycle.
REQ-018 ack on an empty channel SHALL be ignored: no state change.
REQ-019 Simultaneous ack and a transfer to the same full channel SHALL replace the data and keep valid=1, with no bubble.
REQ-020 While E=1: in_ready=0; YA, YB=4'b0000; A_valid, B_valid=0 at the outputs; stored data and valid flags are retained.
REQ-021 While E=1, acks SHALL be ignored.
REQ-022 When E returns to 0, the retained contents SHALL reappear unchanged on the next cycle's outputs.
REQ-023 cnt_A and cnt_B SHALL increment by 1 on each transfer to their channel, saturate at 255, and not wrap.
REQ-024 in_valid=1 with in_ready=0 SHALL cause no state change; the source must hold D.

Reset
REQ-025 With rst=1 at a clk edge, the block SHALL clear YA, YB to 0, A_valid, B_valid to 0, cnt_A, cnt_B to 0, and the toggle bit to 0.
REQ-026 rst SHALL override E, in_valid and ack in the same cycle; any in-flight word is dropped.
REQ-027 in_ready SHALL be 0 while rst=1.

Configuration
REQ-028 With macro DEMUX_AUTO_TOGGLE_EN defined: S is ignored; T=toggle bit; toggle flips after every transfer; the first word after reset goes to A.
REQ-029 With DEMUX_AUTO_TOGGLE_EN defined: if the toggle target is full without ack, in_ready=0 and the toggle does not advance.
REQ-030 With DEMUX_AUTO_TOGGLE_EN undefined: no toggle register exists and T=S.

Verification
REQ-031 Routing scenario: E=0, S=0, D=4'b1010, in_valid one cycle -> next cycle YA=1010, A_valid=1, B_valid=0, cnt_A=1.
REQ-032 Backpressure scenario: A full, S=0, D=4'b0101, no A_ack -> in_ready=0, YA holds 1010.
REQ-033 Pass-through scenario: same state as the backpressure case with A_ack=1 -> in_ready=1, YA=0101 next cycle, A_valid stays 1.
REQ-034 Disable scenario: B full with 4'b0011, E=1 for 3 cycles with B_ack=1 -> YB=0000, B_valid=0, in_ready=0; E=0 -> YB=0011, B_valid=1.
REQ-035 Toggle scenario (macro defined): S held at 1, four words 1,2,3,4 with continuous acks -> YA gets 1 then 3, YB gets 2 then 4, cnt_A=cnt_B=2.
REQ-036 Saturation and reset scenario: 300 transfers to A -> cnt_A=255; rst=1 mid-transfer -> all outputs 0 next cycle.
